// File: rtl/ps2_frame_rx_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PRTY = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int ERR_START   = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_STOP    = 2;
    localparam int ERR_TIMEOUT = 3;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronises ps2_clk/ps2_dat, debounces the clock line and emits a strobe
// on each filtered falling edge of the clock.
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic dat_o,
    output logic fall_o
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   filt_q;
    logic                   filt_d;
    logic                   prev_q;
    logic [FW-1:0]          fcnt_q;
    logic [FW-1:0]          fcnt_d;
    logic                   clk_s;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];

    // Synchroniser chains, filtered level and its one-cycle delayed copy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= {SYNC_STAGES{1'b1}};
            dat_sync_q <= {SYNC_STAGES{1'b1}};
            filt_q     <= 1'b1;
            prev_q     <= 1'b1;
            fcnt_q     <= {FW{1'b0}};
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
            filt_q     <= filt_d;
            prev_q     <= filt_q;
            fcnt_q     <= fcnt_d;
        end
    end

    // Level only flips after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (clk_s == filt_q) begin
            fcnt_d = {FW{1'b0}};
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_s;
            fcnt_d = {FW{1'b0}};
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign dat_o  = dat_sync_q[SYNC_STAGES-1];
    assign fall_o = prev_q & ~filt_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: start, DATA_BITS LSB-first, optional parity, stop.
// Optional abort of stalled frames when PS2_RX_TIMEOUT_EN is defined.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 ps2_clk,
    input  logic                 ps2_dat,
    output logic [DATA_BITS-1:0] rx_word,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [3:0]           err,
    output logic                 overrun
);

    localparam int CW = $clog2(DATA_BITS + 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   word_q, word_d;
    logic                   acc_q, acc_d;
    logic                   perr_q, perr_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;
    logic [3:0]             err_q, err_d;
    logic                   good_s;
    logic                   dat_s;
    logic                   fall_s;
    logic                   tmo_hit_s;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_filter (
        .clk_i     (sysclk),
        .rst_i     (reset),
        .ps2_clk_i (ps2_clk),
        .ps2_dat_i (ps2_dat),
        .dat_o     (dat_s),
        .fall_o    (fall_s)
    );

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Idle-line counter: cleared by any edge and whenever no frame is open
    always_comb begin
        tmo_d     = tmo_q;
        tmo_hit_s = 1'b0;
        if (state_q == IDLE || fall_s) begin
            tmo_d = {TW{1'b0}};
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            tmo_hit_s = 1'b1;
            tmo_d     = {TW{1'b0}};
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tmo_q <= {TW{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Frame decoder; a parity mismatch is only recorded so framing survives
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        perr_d    = perr_q;
        err_d     = 4'b0000;
        good_s    = 1'b0;
        if (tmo_hit_s) begin
            state_d            = IDLE;
            err_d[ERR_TIMEOUT] = 1'b1;
        end else if (fall_s) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s) begin
                        state_d   = DATA;
                        bit_cnt_d = {CW{1'b0}};
                        acc_d     = (PARITY == PAR_ODD) ? 1'b1 : 1'b0;
                        perr_d    = 1'b0;
                    end else begin
                        err_d[ERR_START] = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d   = {dat_s, shreg_q[DATA_BITS-1:1]};
                    acc_d     = acc_q ^ dat_s;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
                        state_d = (PARITY == PAR_NONE) ? STOP : PRTY;
                    end else begin
                        state_d = DATA;
                    end
                end
                PRTY: begin
                    perr_d  = (dat_s != acc_q);
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_s) begin
                        err_d[ERR_STOP] = 1'b1;
                    end else if (perr_q) begin
                        err_d[ERR_PARITY] = 1'b1;
                    end else begin
                        good_s = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Holding register: a full, unaccepted word is never overwritten
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (good_s) begin
            if (valid_q && !rx_ready) begin
                ovr_d = 1'b1;
            end else begin
                word_d  = shreg_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Decoder and output registers
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= {CW{1'b0}};
            shreg_q   <= {DATA_BITS{1'b0}};
            acc_q     <= 1'b0;
            perr_q    <= 1'b0;
            word_q    <= {DATA_BITS{1'b0}};
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            err_q     <= 4'b0000;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            perr_q    <= perr_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            err_q     <= err_d;
        end
    end

    assign rx_word  = word_q;
    assign rx_valid = valid_q;
    assign err      = err_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Randomised bench for ps2_frame_rx: an 8-bit odd-parity instance and a
// 7-bit even-parity instance driven with clock-line glitches.
module tb_ps2_frame_rx;

    localparam int HALF = 20;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       p_clk  = 1'b1;
    logic       p_dat  = 1'b1;
    logic       p_clk2 = 1'b1;
    logic       p_dat2 = 1'b1;
    logic       rx_ready;
    logic       rx_ready2;
    logic [7:0] rx_word;
    logic       rx_valid;
    logic [3:0] err;
    logic       overrun;
    logic [6:0] rx_word2;
    logic       rx_valid2;
    logic [3:0] err2;
    logic       overrun2;

    always #5 sysclk = ~sysclk;

    ps2_frame_rx #(
        .DATA_BITS(8), .PARITY(1), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYC(50)
    ) dut (
        .sysclk(sysclk), .reset(reset), .ps2_clk(p_clk), .ps2_dat(p_dat),
        .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err(err), .overrun(overrun)
    );

    ps2_frame_rx #(
        .DATA_BITS(7), .PARITY(2), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYC(2000)
    ) dut2 (
        .sysclk(sysclk), .reset(reset), .ps2_clk(p_clk2), .ps2_dat(p_dat2),
        .rx_word(rx_word2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
        .err(err2), .overrun(overrun2)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_w[$];
    logic [3:0] got_e[$];
    logic [7:0] exp_w[$];
    logic [3:0] exp_e[$];
    int         ovr_n  = 0;
    int         exp_ovr = 0;
    logic [6:0] got_w2[$];
    int         err2_n = 0;
    int         ovr2_n = 0;

    // Observe both instances away from the active edge
    always @(negedge sysclk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) got_w.push_back(rx_word);
            if (err != 4'b0000) got_e.push_back(err);
            if (overrun) ovr_n++;
            if (rx_valid2 && rx_ready2) got_w2.push_back(rx_word2);
            if (err2 != 4'b0000) err2_n++;
            if (overrun2) ovr2_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic set_clk(input int sel, input logic v);
        if (sel == 0) p_clk = v;
        else          p_clk2 = v;
    endtask

    task automatic set_dat(input int sel, input logic v);
        if (sel == 0) p_dat = v;
        else          p_dat2 = v;
    endtask

    // One line-clock period; optional single-cycle glitch in each half
    task automatic send_bit(input int sel, input logic b, input bit glitch);
        set_dat(sel, b);
        if (glitch) begin
            wait_cyc(HALF / 2); set_clk(sel, 1'b0); wait_cyc(1); set_clk(sel, 1'b1); wait_cyc(HALF / 2 - 1);
        end else begin
            wait_cyc(HALF);
        end
        set_clk(sel, 1'b0);
        if (glitch) begin
            wait_cyc(HALF / 2); set_clk(sel, 1'b1); wait_cyc(1); set_clk(sel, 1'b0); wait_cyc(HALF / 2 - 1);
        end else begin
            wait_cyc(HALF);
        end
        set_clk(sel, 1'b1);
    endtask

    // Wire frame bits [from, upto): start, data LSB first, parity, stop
    task automatic send_frame(input int sel, input int nbits, input logic [8:0] data,
                              input logic par, input logic stop, input bit glitch,
                              input int from, input int upto);
        logic [11:0] fr;
        fr = 12'h000;
        for (int i = 0; i < nbits; i++) fr[1 + i] = data[i];
        fr[nbits + 1] = par;
        fr[nbits + 2] = stop;
        for (int i = from; i < upto; i++) send_bit(sel, fr[i], glitch);
    endtask

    function automatic logic odd_bit(input logic [8:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic even_bit(input logic [8:0] d);
        return ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
    endfunction

    // Compare everything observed on the 8-bit instance with the model
    task automatic settle_and_compare(input string tag);
        wait_cyc(30);
        chk({tag, " err_count"}, got_e.size(), exp_e.size());
        while (got_e.size() > 0 && exp_e.size() > 0) chk({tag, " err_val"}, got_e.pop_front(), exp_e.pop_front());
        chk({tag, " word_count"}, got_w.size(), exp_w.size());
        while (got_w.size() > 0 && exp_w.size() > 0) chk({tag, " word_val"}, got_w.pop_front(), exp_w.pop_front());
        chk({tag, " overrun_count"}, ovr_n, exp_ovr);
        got_e.delete(); exp_e.delete(); got_w.delete(); exp_w.delete();
        ovr_n = 0; exp_ovr = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] d;
        logic       pb;
        int         kind;

        reset = 1'b1; rx_ready = 1'b0; rx_ready2 = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(2);
        chk("reset rx_valid", rx_valid, 1'b0);
        chk("reset rx_word", rx_word, 8'h00);
        chk("reset err", err, 4'b0000);
        chk("reset overrun", overrun, 1'b0);

        // Good 0x1C held until the consumer is ready
        d = 9'h01C;
        send_frame(0, 8, d, odd_bit(d), 1'b1, 1'b0, 0, 11);
        wait_cyc(30);
        chk("good1c rx_valid", rx_valid, 1'b1);
        chk("good1c rx_word", rx_word, 8'h1C);
        rx_ready = 1'b1;
        exp_w.push_back(8'h1C);
        settle_and_compare("good1c");
        chk("good1c drained", rx_valid, 1'b0);

        // Parity error, lone start-error edge, stop error on 0xF0
        send_frame(0, 8, d, ~odd_bit(d), 1'b1, 1'b0, 0, 11);
        exp_e.push_back(4'b0010);
        settle_and_compare("parity");
        send_bit(0, 1'b1, 1'b0);
        exp_e.push_back(4'b0001);
        settle_and_compare("start");
        d = 9'h0F0;
        send_frame(0, 8, d, odd_bit(d), 1'b0, 1'b0, 0, 11);
        exp_e.push_back(4'b0100);
        settle_and_compare("stop");

        // Overrun: second good frame dropped while first is unaccepted
        rx_ready = 1'b0;
        d = 9'h012; send_frame(0, 8, d, odd_bit(d), 1'b1, 1'b0, 0, 11);
        d = 9'h034; send_frame(0, 8, d, odd_bit(d), 1'b1, 1'b0, 0, 11);
        wait_cyc(30);
        chk("overrun rx_valid", rx_valid, 1'b1);
        chk("overrun rx_word", rx_word, 8'h12);
        rx_ready = 1'b1;
        exp_w.push_back(8'h12);
        exp_ovr = 1;
        settle_and_compare("overrun");
        chk("overrun drained", rx_valid, 1'b0);

        // Stalled partial frame: aborted with timeout, or completed later
        d = 9'h05A;
        send_frame(0, 8, d, odd_bit(d), 1'b1, 1'b0, 0, 4);
        wait_cyc(300);
`ifdef PS2_RX_TIMEOUT_EN
        exp_e.push_back(4'b1000);
        settle_and_compare("timeout");
        send_frame(0, 8, d, odd_bit(d), 1'b1, 1'b0, 0, 11);
`else
        settle_and_compare("stall");
        send_frame(0, 8, d, odd_bit(d), 1'b1, 1'b0, 4, 11);
`endif
        exp_w.push_back(8'h5A);
        settle_and_compare("after_stall");

        // Randomised mix of good and faulty frames
        for (int k = 0; k < 16; k++) begin
            kind = $urandom_range(0, 9);
            d    = 9'($urandom_range(0, 255));
            pb   = odd_bit(d);
            if (kind == 0) begin
                send_bit(0, 1'b1, 1'b0);
                exp_e.push_back(4'b0001);
            end else if (kind == 1) begin
                send_frame(0, 8, d, pb ^ 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 11);
                exp_e.push_back(4'b0100);
            end else if (kind <= 3) begin
                send_frame(0, 8, d, ~pb, 1'b1, 1'b0, 0, 11);
                exp_e.push_back(4'b0010);
            end else begin
                send_frame(0, 8, d, pb, 1'b1, 1'b0, 0, 11);
                exp_w.push_back(d[7:0]);
            end
            settle_and_compare($sformatf("rand%0d", k));
        end

        // 7-bit even-parity instance with glitched clock: 0x41 then random
        for (int k = 0; k < 5; k++) begin
            d = (k == 0) ? 9'h041 : 9'($urandom_range(0, 127));
            send_frame(1, 7, d, even_bit(d), 1'b1, 1'b1, 0, 10);
            wait_cyc(30);
            chk($sformatf("glitch%0d count", k), got_w2.size(), 1);
            if (got_w2.size() > 0) chk($sformatf("glitch%0d word", k), got_w2.pop_front(), d[6:0]);
            chk($sformatf("glitch%0d err", k), err2_n, 0);
            chk($sformatf("glitch%0d overrun", k), ovr2_n, 0);
            got_w2.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
